// File: rtl/clkdiv_scan_pkg.sv
// ============================================================================
// Module      : clkdiv_scan_pkg
// Description : Shared constants and helpers for the fractional divider
//               scan blinker (ratio table, index width, accumulator width).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkdiv_scan_pkg;

    localparam int ACC_W = 4;

    // Twice the division ratio, so half-step ratios stay integral: 2, 3.5, 4, 5.
    localparam int DIV_X2_TBL [4] = '{4, 7, 8, 10};

    function automatic int div_x2(input int i);
        return DIV_X2_TBL[i % 4];
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_scan_blinker_frac_div_ch.sv
// ============================================================================
// Module      : frac_div_ch
// Description : One fractional clock-enable divider channel with a
//               free-running counter; hold freezes accumulator and counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_div_ch
    import clkdiv_scan_pkg::*;
#(
    parameter int DIV_X2 = 4,
    parameter int CNT_W  = 24
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hold,
    output logic             en_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [ACC_W-1:0] DIV_C = ACC_W'(DIV_X2);

    logic [ACC_W-1:0] acc_q, acc_d, acc_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;

    // Accumulate in half-steps; each overflow past DIV_X2 is one output enable.
    always_comb begin
        acc_n = acc_q + ACC_W'(2);
        acc_d = acc_q;
        cnt_d = cnt_q;
        en_d  = 1'b0;
        if (!hold) begin
            if (acc_n >= DIV_C) begin
                acc_d = acc_n - DIV_C;
                en_d  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                acc_d = acc_n;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

    assign en_o  = en_q;
    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/clkdiv_scan_blinker.sv
// ============================================================================
// Module      : clkdiv_scan_blinker
// Description : Board exerciser: NUM_CH fractional dividers, dwell-rotated
//               LED select, debounced freeze button. Optional manual stepping
//               on button press via macro CLKDIV_SCAN_MANUAL_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkdiv_scan_blinker
    import clkdiv_scan_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 24,
    parameter int DWELL_W = 30,
    parameter int DEB_W   = 16,
    parameter int LEDS_NR = 2,
    parameter bit INV_BTN = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               key_i,
    output logic [LEDS_NR-1:0] led
);

    localparam int IDX_W = idx_w(NUM_CH);
    localparam int SEL_N = 2 ** IDX_W;

    logic                    sync1_q, sync2_q, sync_prev_q;
    logic [DEB_W-1:0]        deb_q;
    logic                    key_db_q;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic                    dwell_msb_q, dwell_msb_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic                    step;
    logic [NUM_CH*CNT_W-1:0] cnt_all;
    logic [NUM_CH-1:0]       en_all;
    logic [SEL_N-1:0]        msb_vec;
    logic [LEDS_NR-1:0]      led_d;
    logic                    unused_bits;

    // Synchronise, then accept the key only after it has been stable long enough.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            deb_q       <= '0;
            key_db_q    <= 1'b0;
        end else begin
            sync1_q     <= key_i ^ INV_BTN;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            if (sync2_q != sync_prev_q) begin
                deb_q <= '0;
            end else if (deb_q != '1) begin
                deb_q <= deb_q + DEB_W'(1);
            end else begin
                key_db_q <= sync2_q;
            end
        end
    end

`ifdef CLKDIV_SCAN_MANUAL_STEP_EN
    logic key_db_prev_q;
    logic key_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_db_prev_q <= 1'b0;
        end else begin
            key_db_prev_q <= key_db_q;
        end
    end

    // Clearing the MSB history with dwell keeps the restart from looking like a toggle.
    assign key_rise    = key_db_q & ~key_db_prev_q;
    assign dwell_d     = key_rise ? '0 : dwell_q + DWELL_W'(1);
    assign dwell_msb_d = key_rise ? 1'b0 : dwell_q[DWELL_W-1];
    assign step        = (dwell_q[DWELL_W-1] != dwell_msb_q) | key_rise;
`else
    assign dwell_d     = dwell_q + DWELL_W'(1);
    assign dwell_msb_d = dwell_q[DWELL_W-1];
    assign step        = (dwell_q[DWELL_W-1] != dwell_msb_q);
`endif

    assign sel_d = !step ? sel_q :
                   (sel_q == IDX_W'(NUM_CH - 1)) ? '0 : sel_q + IDX_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dwell_q     <= '0;
            dwell_msb_q <= 1'b0;
            sel_q       <= '0;
        end else begin
            dwell_q     <= dwell_d;
            dwell_msb_q <= dwell_msb_d;
            sel_q       <= sel_d;
        end
    end

    // Pad the select space to a power of two so the mux index is always in range.
    for (genvar i = 0; i < SEL_N; i++) begin : g_ch
        if (i < NUM_CH) begin : g_real
            frac_div_ch #(
                .DIV_X2 (div_x2(i)),
                .CNT_W  (CNT_W)
            ) u_ch (
                .clk    (clk),
                .resetn (resetn),
                .hold   (key_db_q),
                .en_o   (en_all[i]),
                .cnt_o  (cnt_all[i*CNT_W +: CNT_W])
            );
            assign msb_vec[i] = cnt_all[i*CNT_W + CNT_W - 1];
        end else begin : g_pad
            assign msb_vec[i] = 1'b0;
        end
    end

    assign led_d[LEDS_NR-1] = msb_vec[sel_q];

    if (LEDS_NR >= 2) begin : g_hb
        assign led_d[0] = dwell_q[CNT_W-1];
    end

    for (genvar j = 1; j < LEDS_NR - 1; j++) begin : g_mid
        if (j - 1 < IDX_W) begin : g_bit
            assign led_d[j] = sel_q[j-1];
        end else begin : g_zero
            assign led_d[j] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

    assign unused_bits = ^{en_all, cnt_all};

endmodule

`default_nettype wire
